// File: rtl/bram_arbiter.sv
// Two-requester arbiter in front of a single-port BRAM.
// Round-robin with bounded locked bursts; read data routed back by issuer tag.
module bram_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  M0_req,
    input  logic [DATA_W/8-1:0]   M0_we,
    input  logic [ADDR_W-1:0]     M0_addr,
    input  logic [DATA_W-1:0]     M0_wdata,
    input  logic                  M0_lock,
    output logic                  M0_gnt,
    output logic                  M0_rvalid,
    output logic [DATA_W-1:0]     M0_rdata,
    input  logic                  M1_req,
    input  logic [DATA_W/8-1:0]   M1_we,
    input  logic [ADDR_W-1:0]     M1_addr,
    input  logic [DATA_W-1:0]     M1_wdata,
    input  logic                  M1_lock,
    output logic                  M1_gnt,
    output logic                  M1_rvalid,
    output logic [DATA_W-1:0]     M1_rdata,
    output logic                  B_R_req,
    output logic [ADDR_W-1:0]     B_addr,
    output logic [DATA_W/8-1:0]   B_W_req,
    output logic [DATA_W-1:0]     B_W_data,
    input  logic [DATA_W-1:0]     B_R_data
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    state_t              state_q, state_d;
    logic                rr_q, rr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     wreq_q, wreq_d;
    logic [RD_LAT:0]     vld_q, vld_d;
    logic [RD_LAT:0]     id_q, id_d;

    logic                acc;
    logic                sel;
    logic [BE_W-1:0]     s_we;
    logic [ADDR_W-1:0]   s_addr;
    logic [DATA_W-1:0]   s_wdata;
    logic                s_lock;
    logic                own;
    logic                own_req;
    logic                own_lock;

    always_comb begin
        M0_gnt = 1'b0;
        M1_gnt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (M0_req && M1_req) begin
                    M0_gnt = ~rr_q;
                    M1_gnt = rr_q;
                end else begin
                    M0_gnt = M0_req;
                    M1_gnt = M1_req;
                end
            end
            OWN0: M0_gnt = M0_req;
            OWN1: M1_gnt = M1_req;
            default: ;
        endcase
    end

    assign acc      = M0_gnt | M1_gnt;
    assign sel      = M1_gnt;
    assign s_we     = sel ? M1_we    : M0_we;
    assign s_addr   = sel ? M1_addr  : M0_addr;
    assign s_wdata  = sel ? M1_wdata : M0_wdata;
    assign s_lock   = sel ? M1_lock  : M0_lock;
    assign own      = (state_q == OWN1);
    assign own_req  = own ? M1_req  : M0_req;
    assign own_lock = own ? M1_lock : M0_lock;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    rr_d = ~sel;
                    if (s_lock && MAX_BURST > 1) begin
                        state_d = sel ? OWN1 : OWN0;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            OWN0, OWN1: begin
                if (acc) begin
                    if (!s_lock) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        // burst limit hit: hand priority to the waiting side
                        state_d = IDLE;
                        rr_d    = ~own;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (!own_req && !own_lock) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        addr_d  = acc ? s_addr  : addr_q;
        wdata_d = acc ? s_wdata : wdata_q;
        wreq_d  = acc ? s_we    : '0;
        vld_d   = {vld_q[RD_LAT-1:0], acc && (s_we == '0)};
        id_d    = {id_q[RD_LAT-1:0], sel};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wreq_q  <= '0;
            vld_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wreq_q  <= wreq_d;
            vld_q   <= vld_d;
            id_q    <= id_d;
        end
    end

    // tag stage 0 coincides with the read strobe on the BRAM port
    assign B_R_req   = vld_q[0];
    assign B_addr    = addr_q;
    assign B_W_req   = wreq_q;
    assign B_W_data  = wdata_q;
    assign M0_rvalid = vld_q[RD_LAT] & ~id_q[RD_LAT];
    assign M1_rvalid = vld_q[RD_LAT] &  id_q[RD_LAT];
    assign M0_rdata  = B_R_data;
    assign M1_rdata  = B_R_data;

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter with a behavioural BRAM
// and a rule-level arbitration / shadow-memory reference model.
module tb_bram_arbiter;

    localparam int AW     = 8;
    localparam int DW     = 32;
    localparam int RD_LAT = 1;
    localparam int MAXB   = 16;

    logic          clk;
    logic          rst;
    logic          M0_req, M1_req;
    logic [3:0]    M0_we, M1_we;
    logic [AW-1:0] M0_addr, M1_addr;
    logic [DW-1:0] M0_wdata, M1_wdata;
    logic          M0_lock, M1_lock;
    logic          M0_gnt, M1_gnt;
    logic          M0_rvalid, M1_rvalid;
    logic [DW-1:0] M0_rdata, M1_rdata;
    logic          B_R_req;
    logic [AW-1:0] B_addr;
    logic [3:0]    B_W_req;
    logic [DW-1:0] B_W_data;
    logic [DW-1:0] B_R_data;

    int n_cmp;
    int n_bad;

    logic          bd_en;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;
    logic [DW-1:0] mem    [0:255];
    logic [DW-1:0] shadow [0:255];
    logic [DW-1:0] rd_q;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    bram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAXB)
    ) dut (
        .clk(clk), .rst(rst),
        .M0_req(M0_req), .M0_we(M0_we), .M0_addr(M0_addr),
        .M0_wdata(M0_wdata), .M0_lock(M0_lock), .M0_gnt(M0_gnt),
        .M0_rvalid(M0_rvalid), .M0_rdata(M0_rdata),
        .M1_req(M1_req), .M1_we(M1_we), .M1_addr(M1_addr),
        .M1_wdata(M1_wdata), .M1_lock(M1_lock), .M1_gnt(M1_gnt),
        .M1_rvalid(M1_rvalid), .M1_rdata(M1_rdata),
        .B_R_req(B_R_req), .B_addr(B_addr), .B_W_req(B_W_req),
        .B_W_data(B_W_data), .B_R_data(B_R_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [3:0] be,
                                          input logic [31:0] d);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) res[b*8 +: 8] = d[b*8 +: 8];
        return res;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else begin
            if (bd_en) mem[bd_addr] <= bd_data;
            for (int b = 0; b < 4; b++)
                if (B_W_req[b]) mem[B_addr][b*8 +: 8] <= B_W_data[b*8 +: 8];
            if (B_R_req) rd_q <= mem[B_addr];
        end
    end
    assign B_R_data = rd_q;

    task automatic idle_inputs;
        M0_req = 0; M0_we = 0; M0_addr = 0; M0_wdata = 0; M0_lock = 0;
        M1_req = 0; M1_we = 0; M1_addr = 0; M1_wdata = 0; M1_lock = 0;
    endtask

    task automatic shadow_init;
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        shadow_init();
    endtask

    task automatic backdoor(input logic [7:0] a, input logic [31:0] d);
        bd_en = 1; bd_addr = a; bd_data = d;
        shadow[a] = d;
        next_cycle();
        bd_en = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        n_cmp++;
        if (B_R_req !== 0 || B_W_req !== 0 || B_addr !== 0 ||
            B_W_data !== 0 || M0_rvalid !== 0 || M1_rvalid !== 0) begin
            n_bad++;
            $display("FAIL reset_state: rreq=%b wreq=%h addr=%h wd=%h rv=%b%b want 0",
                     B_R_req, B_W_req, B_addr, B_W_data, M0_rvalid, M1_rvalid);
        end
        rst = 0;
        shadow_init();
        M0_req = 1; M0_we = 0; M0_addr = 8'h55;
        @(negedge clk);
        n_cmp++;
        if (M0_gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_pre_gnt: got %b want 1", M0_gnt);
        end
        next_cycle();
        idle_inputs();
        n_cmp++;
        if (B_R_req !== 1'b1 || B_addr !== 8'h55) begin
            n_bad++;
            $display("FAIL reset_pre_issue: rreq=%b addr=%h want 1/55",
                     B_R_req, B_addr);
        end
        #2 rst = 1;
        #1;
        n_cmp++;
        if (B_R_req !== 0 || B_W_req !== 0 || B_addr !== 0 ||
            B_W_data !== 0 || M0_rvalid !== 0 || M1_rvalid !== 0) begin
            n_bad++;
            $display("FAIL reset_async: rreq=%b wreq=%h addr=%h rv=%b%b want 0",
                     B_R_req, B_W_req, B_addr, M0_rvalid, M1_rvalid);
        end
        next_cycle();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (M0_rvalid !== 0 || M1_rvalid !== 0) begin
                n_bad++;
                $display("FAIL reset_no_rvalid: cyc %0d rv=%b%b want 00",
                         i, M0_rvalid, M1_rvalid);
            end
        end
        next_cycle();
    endtask

    task automatic test_single_read;
        do_reset();
        backdoor(8'h10, 32'hDEAD_BEEF);
        M0_req = 1; M0_we = 0; M0_addr = 8'h10;
        @(negedge clk);
        n_cmp++;
        if (M0_gnt !== 1 || M1_gnt !== 0 || M0_rvalid !== 0) begin
            n_bad++;
            $display("FAIL single_gnt: gnt=%b%b rv0=%b want 1,0,0",
                     M0_gnt, M1_gnt, M0_rvalid);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (B_R_req !== 1 || B_addr !== 8'h10 || M0_rvalid !== 0 ||
            M1_rvalid !== 0) begin
            n_bad++;
            $display("FAIL single_issue: rreq=%b addr=%h rv=%b%b want 1,10,00",
                     B_R_req, B_addr, M0_rvalid, M1_rvalid);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (M0_rvalid !== 1 || M0_rdata !== 32'hDEAD_BEEF || M1_rvalid !== 0) begin
            n_bad++;
            $display("FAIL single_return: rv0=%b data=%h rv1=%b want 1,deadbeef,0",
                     M0_rvalid, M0_rdata, M1_rvalid);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (M0_rvalid !== 0 || M1_rvalid !== 0 || B_R_req !== 0) begin
            n_bad++;
            $display("FAIL single_after: rv=%b%b rreq=%b want 0",
                     M0_rvalid, M1_rvalid, B_R_req);
        end
        next_cycle();
    endtask

    task automatic test_contention;
        do_reset();
        M0_req = 1; M0_we = 0; M0_addr = 8'h01;
        M1_req = 1; M1_we = 0; M1_addr = 8'h02;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (M0_gnt !== (i % 2 == 0) || M1_gnt !== (i % 2 == 1)) begin
                n_bad++;
                $display("FAIL contention_gnt: cyc %0d gnt=%b%b want %b%b",
                         i, M0_gnt, M1_gnt, i % 2 == 0, i % 2 == 1);
            end
            if (i >= 1) begin
                n_cmp++;
                if (B_R_req !== 1 || B_addr !== ((i % 2 == 1) ? 8'h01 : 8'h02)) begin
                    n_bad++;
                    $display("FAIL contention_issue: cyc %0d rreq=%b addr=%h",
                             i, B_R_req, B_addr);
                end
            end
            if (i >= 2) begin
                n_cmp++;
                if (M0_rvalid !== (i % 2 == 0) || M1_rvalid !== (i % 2 == 1) ||
                    M0_rdata !== ((i % 2 == 0) ? shadow[1] : shadow[2])) begin
                    n_bad++;
                    $display("FAIL contention_ret: cyc %0d rv=%b%b data=%h",
                             i, M0_rvalid, M1_rvalid, M0_rdata);
                end
            end
            next_cycle();
        end
        idle_inputs();
        repeat (3) next_cycle();
    endtask

    task automatic test_lock;
        logic [31:0] d;
        do_reset();
        M0_req = 1; M0_we = 4'hF; M0_addr = 8'h40; M0_wdata = 32'h0BAD_F00D;
        @(negedge clk);
        n_cmp++;
        if (M0_gnt !== 1) begin
            n_bad++;
            $display("FAIL lock_pre: gnt0=%b want 1", M0_gnt);
        end
        shadow[8'h40] = 32'h0BAD_F00D;
        next_cycle();
        M0_we = 0; M0_addr = 8'h21;
        for (int k = 0; k < 4; k++) begin
            d = $urandom;
            M1_req = 1; M1_we = 4'hF; M1_addr = 8'(8'h20 + k);
            M1_wdata = d; M1_lock = (k < 3);
            @(negedge clk);
            n_cmp++;
            if (M1_gnt !== 1 || M0_gnt !== 0) begin
                n_bad++;
                $display("FAIL lock_hold: beat %0d gnt=%b%b want 0,1",
                         k, M0_gnt, M1_gnt);
            end
            shadow[8'h20 + k] = d;
            if (k >= 1) begin
                n_cmp++;
                if (B_W_req !== 4'hF || B_addr !== 8'(8'h20 + k - 1)) begin
                    n_bad++;
                    $display("FAIL lock_issue: beat %0d wreq=%h addr=%h",
                             k, B_W_req, B_addr);
                end
            end
            next_cycle();
        end
        M1_req = 0; M1_lock = 0; M1_we = 0;
        @(negedge clk);
        n_cmp++;
        if (M0_gnt !== 1 || M1_gnt !== 0 || B_W_req !== 4'hF ||
            B_addr !== 8'h23) begin
            n_bad++;
            $display("FAIL lock_release: gnt=%b%b wreq=%h addr=%h want 1,0,f,23",
                     M0_gnt, M1_gnt, B_W_req, B_addr);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (B_R_req !== 1 || B_addr !== 8'h21 || B_W_req !== 0) begin
            n_bad++;
            $display("FAIL lock_rd_issue: rreq=%b addr=%h wreq=%h",
                     B_R_req, B_addr, B_W_req);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (M0_rvalid !== 1 || M0_rdata !== shadow[8'h21]) begin
            n_bad++;
            $display("FAIL lock_raw: rv0=%b data=%h want 1,%h",
                     M0_rvalid, M0_rdata, shadow[8'h21]);
        end
        next_cycle();
    endtask

    task automatic test_forced_release;
        do_reset();
        M1_req = 1; M1_we = 0; M1_addr = 8'h07;
        for (int i = 0; i < 21; i++) begin
            M0_req = 1; M0_we = 0; M0_lock = (i != 20);
            if (i != 17) M0_addr = 8'($urandom_range(0, 255));
            M1_req = (i <= 16);
            @(negedge clk);
            n_cmp++;
            if (M0_gnt !== (i != 16) || M1_gnt !== (i == 16)) begin
                n_bad++;
                $display("FAIL forced_release: cyc %0d gnt=%b%b want %b%b",
                         i, M0_gnt, M1_gnt, i != 16, i == 16);
            end
            next_cycle();
        end
        idle_inputs();
        repeat (3) next_cycle();
    endtask

    task automatic test_byte_write;
        do_reset();
        backdoor(8'h30, 32'h1122_3344);
        M0_req = 1; M0_we = 4'b0010; M0_addr = 8'h30; M0_wdata = 32'h0000_AB00;
        @(negedge clk);
        n_cmp++;
        if (M0_gnt !== 1) begin
            n_bad++;
            $display("FAIL byte_gnt: gnt0=%b want 1", M0_gnt);
        end
        next_cycle();
        idle_inputs();
        M1_req = 1; M1_we = 0; M1_addr = 8'h30;
        @(negedge clk);
        n_cmp++;
        if (M1_gnt !== 1 || B_W_req !== 4'b0010 || B_W_data !== 32'h0000_AB00) begin
            n_bad++;
            $display("FAIL byte_issue: gnt1=%b wreq=%b wd=%h want 1,0010,0000ab00",
                     M1_gnt, B_W_req, B_W_data);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (M1_rvalid !== 1 || M1_rdata !== 32'h1122_AB44 || M0_rvalid !== 0) begin
            n_bad++;
            $display("FAIL byte_readback: rv1=%b data=%h rv0=%b want 1,1122ab44,0",
                     M1_rvalid, M1_rdata, M0_rvalid);
        end
        next_cycle();
    endtask

    task automatic test_random;
        logic        r  [2];
        logic [3:0]  we [2];
        logic [7:0]  ad [2];
        logic [31:0] wd [2];
        logic        lk [2];
        exp_t        q0 [$];
        exp_t        q1 [$];
        exp_t        e;
        int          own, rr, cnt, w;
        logic        ev;
        do_reset();
        own = -1; rr = 0; cnt = 0;
        for (int m = 0; m < 2; m++) begin
            r[m] = 0; we[m] = 0; ad[m] = 0; wd[m] = 0; lk[m] = 0;
        end
        for (int c = 0; c < 2006; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!r[m]) begin
                    r[m]  = (c < 2000) && ($urandom_range(0, 3) != 0);
                    we[m] = ($urandom_range(0, 1) == 0) ? 4'h0
                            : 4'($urandom_range(1, 15));
                    ad[m] = 8'($urandom_range(0, 31));
                    wd[m] = $urandom;
                    lk[m] = (c < 2000) && ($urandom_range(0, 3) == 0);
                end
            end
            M0_req = r[0]; M0_we = we[0]; M0_addr = ad[0];
            M0_wdata = wd[0]; M0_lock = lk[0];
            M1_req = r[1]; M1_we = we[1]; M1_addr = ad[1];
            M1_wdata = wd[1]; M1_lock = lk[1];
            @(negedge clk);
            if (own < 0) begin
                if (r[0] && r[1]) w = rr;
                else if (r[0]) w = 0;
                else if (r[1]) w = 1;
                else w = -1;
            end else begin
                w = r[own] ? own : -1;
            end
            n_cmp++;
            if (M0_gnt !== (w == 0) || M1_gnt !== (w == 1)) begin
                n_bad++;
                $display("FAIL random_gnt: cyc %0d gnt=%b%b want %b%b",
                         c, M0_gnt, M1_gnt, w == 0, w == 1);
            end
            ev = (q0.size() > 0) && (q0[0].due == c);
            n_cmp++;
            if (M0_rvalid !== ev || (ev && M0_rdata !== q0[0].data)) begin
                n_bad++;
                $display("FAIL random_rv0: cyc %0d rv=%b data=%h want %b %h",
                         c, M0_rvalid, M0_rdata, ev, ev ? q0[0].data : 32'h0);
            end
            if (ev) void'(q0.pop_front());
            ev = (q1.size() > 0) && (q1[0].due == c);
            n_cmp++;
            if (M1_rvalid !== ev || (ev && M1_rdata !== q1[0].data)) begin
                n_bad++;
                $display("FAIL random_rv1: cyc %0d rv=%b data=%h want %b %h",
                         c, M1_rvalid, M1_rdata, ev, ev ? q1[0].data : 32'h0);
            end
            if (ev) void'(q1.pop_front());
            if (w >= 0) begin
                if (we[w] == 0) begin
                    e.due  = c + 1 + RD_LAT;
                    e.data = shadow[ad[w]];
                    if (w == 0) q0.push_back(e);
                    else q1.push_back(e);
                end else begin
                    shadow[ad[w]] = merge(shadow[ad[w]], we[w], wd[w]);
                end
                if (own < 0) begin
                    rr = 1 - w;
                    if (lk[w] && MAXB > 1) begin
                        own = w;
                        cnt = 1;
                    end
                end else if (!lk[w]) begin
                    own = -1;
                end else if (cnt + 1 == MAXB) begin
                    own = -1;
                    rr = 1 - w;
                end else begin
                    cnt++;
                end
                r[w] = 0;
            end else if (own >= 0 && !r[own] && !lk[own]) begin
                own = -1;
            end
            next_cycle();
        end
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_bad++;
            $display("FAIL random_drain: pending %0d/%0d want 0/0",
                     q0.size(), q1.size());
        end
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time %0t exceeded bound", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        bd_en = 0; bd_addr = 0; bd_data = 0;
        rst = 1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_lock();
        test_forced_release();
        test_byte_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
